// File: rtl/loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package loader_pkg;

  localparam int unsigned AW_DEF = 8;
  localparam int unsigned DW_DEF = 8;
  localparam logic [DW_DEF-1:0] SYNC_DEFAULT = 8'hA5;

  typedef logic [DW_DEF-1:0] byte_t;
  typedef logic [AW_DEF-1:0] addr_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4
  } state_t;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte idle counter; expire_c flags LIMIT idle cycles inside a frame (LIMIT=0 disables).
module loader_timeout #(
  parameter int unsigned LIMIT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic clear,
  output logic expire_c
);

  localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  // Saturates at LIMIT so a stalled FSM keeps seeing the expiry.
  always_ff @(posedge clk) begin
    if (!rst_n || clear || !active) begin
      cnt_q <= '0;
    end else if (cnt_q != CW'(LIMIT)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expire_c = (LIMIT != 0) && active && (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream writer for the program RAM; holds the CPU while a frame is in flight.
// Define LOADER_CHECKSUM_EN to require a trailing checksum byte per frame.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned     AW          = AW_DEF,
  parameter int unsigned     DW          = DW_DEF,
  parameter logic [DW-1:0]   SYNC_BYTE   = DW'(SYNC_DEFAULT),
  parameter int unsigned     TIMEOUT_CYC = 1000000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          we,
  output logic [AW-1:0] w_addr,
  output logic [DW-1:0] w_data,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  localparam int unsigned CNTW = AW + 1;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   sum_q, sum_d;
  logic [AW-1:0]   w_addr_d;
  logic [DW-1:0]   w_data_d;
  logic            we_d, cpu_hold_d, done_d, err_d;
  logic            accept, expire_c;

  assign accept = in_valid & in_ready;

  loader_timeout #(.LIMIT(TIMEOUT_CYC)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .active   (state_q != IDLE),
    .clear    (accept),
    .expire_c (expire_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      in_ready <= 1'b0;
      we       <= 1'b0;
      w_addr   <= '0;
      w_data   <= '0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      in_ready <= 1'b1;
      we       <= we_d;
      w_addr   <= w_addr_d;
      w_data   <= w_data_d;
      cpu_hold <= cpu_hold_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

  // Timeout wins over a byte arriving in the same cycle: the gap has already been exceeded.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    we_d       = 1'b0;
    w_addr_d   = w_addr;
    w_data_d   = w_data;
    cpu_hold_d = cpu_hold;
    done_d     = 1'b0;
    err_d      = 1'b0;
    if (expire_c) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (in_data == SYNC_BYTE) begin
            state_d    = ADDR;
            cpu_hold_d = 1'b1;
          end
        end
        ADDR: begin
          ptr_d   = AW'(in_data);
          sum_d   = in_data;
          state_d = LEN;
        end
        LEN: begin
          cnt_d   = (in_data == '0) ? CNTW'(2 ** AW) : CNTW'(in_data);
          sum_d   = sum_q + in_data;
          state_d = DATA;
        end
        DATA: begin
          we_d     = 1'b1;
          w_addr_d = ptr_q;
          w_data_d = in_data;
          ptr_d    = ptr_q + AW'(1);
          sum_d    = sum_q + in_data;
          cnt_d    = cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) begin
`ifdef LOADER_CHECKSUM_EN
            state_d    = CSUM;
`else
            state_d    = IDLE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: begin
          state_d = IDLE;
          if (DW'(sum_q + in_data) == '0) begin
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; frames carry a checksum byte when LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;

  localparam int unsigned TO = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready, we, cpu_hold, done, err;
  logic [7:0] w_addr, w_data;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [7:0] wa[$];
  logic [7:0] wd[$];
  logic [7:0] pl[256];

  prog_loader #(.AW(8), .DW(8), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .we       (we),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Record every write and pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (we) begin
      wa.push_back(w_addr);
      wd.push_back(w_data);
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done || err) chk("done_err_exclusive", 32'(done & err), 32'd0);
  end

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic fill(input logic [7:0] seed);
    for (int i = 0; i < 256; i++) pl[i] = 8'(i * 7) ^ seed;
  endtask

  task automatic run_frame(input logic [7:0] addr, input int len, input bit bad_csum);
    logic [7:0] l8;
    logic [7:0] sum;
    l8  = 8'(len);
    sum = addr + l8;
    send(8'hA5);
    chk("hold_after_sync", 32'(cpu_hold), 32'd1);
    send(addr);
    send(l8);
    for (int i = 0; i < len; i++) begin
      send(pl[i]);
      sum = sum + pl[i];
    end
`ifdef LOADER_CHECKSUM_EN
    send(bad_csum ? 8'h00 : 8'h00 - sum);
`else
    if (bad_csum) $display("note: checksum disabled, bad_csum ignored");
`endif
    repeat (3) @(negedge clk);
  endtask

  task automatic check_writes(input string tag, input logic [7:0] addr, input int len);
    chk({tag, "_wr_count"}, 32'(wa.size()), 32'(len));
    for (int i = 0; i < len && i < wa.size(); i++) begin
      chk({tag, "_wr_addr"}, 32'(wa[i]), 32'(8'(addr + 8'(i))));
      chk({tag, "_wr_data"}, 32'(wd[i]), 32'(pl[i]));
    end
  endtask

  task automatic check_ok(input string tag);
    chk({tag, "_done"}, 32'(done_cnt), 32'd1);
    chk({tag, "_err"}, 32'(err_cnt), 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_w_addr", 32'(w_addr), 32'd0);
    chk("rst_w_data", 32'(w_data), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    // Basic frame 10:11,22,33
    clear_log();
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    run_frame(8'h10, 3, 1'b0);
    check_writes("t1", 8'h10, 3);
    check_ok("t1");

`ifdef LOADER_CHECKSUM_EN
    // Same frame, wrong checksum: writes stay, err, hold stays up
    clear_log();
    run_frame(8'h10, 3, 1'b1);
    check_writes("t2", 8'h10, 3);
    chk("t2_done", 32'(done_cnt), 32'd0);
    chk("t2_err", 32'(err_cnt), 32'd1);
    chk("t2_hold", 32'(cpu_hold), 32'd1);
`endif

    // Address wrap FE,FF,00
    clear_log();
    fill(8'h5C);
    run_frame(8'hFE, 3, 1'b0);
    check_writes("t3", 8'hFE, 3);
    check_ok("t3");

    // Junk before sync is dropped, then a full 256-byte frame
    clear_log();
    fill(8'h3C);
    send(8'h00);
    send(8'h5A);
    repeat (2) @(negedge clk);
    chk("t4_junk_writes", 32'(wa.size()), 32'd0);
    chk("t4_junk_hold", 32'(cpu_hold), 32'd0);
    run_frame(8'h01, 256, 1'b0);
    check_writes("t4", 8'h01, 256);
    check_ok("t4");

    // Stall after address byte -> timeout
    clear_log();
    send(8'hA5);
    send(8'h20);
    waited = 0;
    while (err_cnt == 0 && waited < int'(TO) + 10) begin
      @(negedge clk);
      waited++;
    end
    chk("t5_err_seen", 32'(err_cnt), 32'd1);
    chk("t5_not_early", 32'(waited >= int'(TO)), 32'd1);
    chk("t5_no_we", 32'(wa.size()), 32'd0);
    chk("t5_no_done", 32'(done_cnt), 32'd0);
    chk("t5_hold", 32'(cpu_hold), 32'd1);
    clear_log();
    fill(8'hA5);
    run_frame(8'h80, 4, 1'b0);
    check_writes("t5b", 8'h80, 4);
    check_ok("t5b");

    // Reset in the middle of DATA
    clear_log();
    fill(8'h11);
    send(8'hA5);
    send(8'h40);
    send(8'h05);
    send(pl[0]);
    send(pl[1]);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_we", 32'(we), 32'd0);
    chk("t6_hold", 32'(cpu_hold), 32'd0);
    chk("t6_ready", 32'(in_ready), 32'd0);
    chk("t6_partial_writes", 32'(wa.size()), 32'd2);
    rst_n = 1'b1;
    @(negedge clk);
    clear_log();
    fill(8'h77);
    run_frame(8'h50, 2, 1'b0);
    check_writes("t6b", 8'h50, 2);
    check_ok("t6b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
